// File: rtl/debounce_pkg.sv
// Shared debounce types: FSM state encoding and the default stable-time constant.
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 1000000;

    typedef enum logic [1:0] {
        LOW_STABLE,
        WAIT_HIGH,
        HIGH_STABLE,
        WAIT_LOW
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; two-cycle latency, no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce.sv
// Switch debouncer: a new level must hold STABLE_CYCLES before btn_level follows.
// Latency STABLE_CYCLES+2 edges with DEBOUNCE_SYNC_EN (two-flop sync), else STABLE_CYCLES+1.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    // Derived width; must track STABLE_CYCLES, not be set on its own.
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );
`else
    // Input already synchronous to clk: one capture flop only.
    logic s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= 1'b0;
        end else begin
            s_q <= btn_in;
        end
    end

    assign s = s_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        busy_d  = busy_q;
        unique case (state_q)
            LOW_STABLE, HIGH_STABLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (s != level_q) begin
                    state_d = (state_q == LOW_STABLE) ? WAIT_HIGH : WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            WAIT_HIGH, WAIT_LOW: begin
                if (s == level_q) begin
                    // Bounce: drop the candidate and fall back to the settled level.
                    state_d = (state_q == WAIT_HIGH) ? LOW_STABLE : HIGH_STABLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = (state_q == WAIT_HIGH) ? HIGH_STABLE : LOW_STABLE;
                    level_d = ~level_q;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
                level_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce with STABLE_CYCLES=4; latency expectations follow DEBOUNCE_SYNC_EN.
module tb_debounce;

    localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int L = S + D;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference: input delayed by D cycles, then level flips after S consecutive differing samples.
    bit m_dly[$];
    bit m_level;
    int m_run;

    always #5 clk = ~clk;

    debounce #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .busy      (busy)
    );

    task automatic tick();
        bit r;
        bit b;
        bit s_old;
        r = rst;
        b = btn_in;
        @(posedge clk);
        if (r) begin
            m_dly.delete();
            for (int i = 0; i < D; i++) m_dly.push_back(1'b0);
            m_level = 1'b0;
            m_run   = 0;
        end else begin
            s_old = m_dly[D-1];
            m_dly.push_front(b);
            void'(m_dly.pop_back());
            if (s_old != m_level) m_run++;
            else m_run = 0;
            if (m_run == S) begin
                m_level = ~m_level;
                m_run   = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        tests_run++;
        if (btn_level !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_level: got %b want 0", btn_level);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (btn_level !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: level %b busy %b want 0 0", btn_level, busy);
        end
    endtask

    task automatic test_clean_press();
        btn_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            tests_run++;
            if (btn_level !== (n >= L)) begin
                tests_failed++;
                $display("FAIL press_level edge %0d: got %b want %b", n, btn_level, n >= L);
            end
            tests_run++;
            if (busy !== (n >= L - 3 && n < L)) begin
                tests_failed++;
                $display("FAIL press_busy edge %0d: got %b want %b", n, busy, n >= L - 3 && n < L);
            end
        end
    endtask

    task automatic test_release();
        btn_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            tests_run++;
            if (btn_level !== (n < L)) begin
                tests_failed++;
                $display("FAIL release_level edge %0d: got %b want %b", n, btn_level, n < L);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 12; k++) begin
            btn_in = ((k / 2) % 2 == 0);
            tick();
            tests_run++;
            if (btn_level !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_hold cycle %0d: got %b want 0", k, btn_level);
            end
        end
        btn_in = 1'b1;
        for (int n = 1; n <= L + 2; n++) begin
            tick();
            tests_run++;
            if (btn_level !== (n >= L)) begin
                tests_failed++;
                $display("FAIL bounce_settle edge %0d: got %b want %b", n, btn_level, n >= L);
            end
        end
        btn_in = 1'b0;
        for (int n = 0; n < L + 2; n++) tick();
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            btn_in = (k < 3);
            tick();
            if (busy === 1'b1) busy_cnt++;
            tests_run++;
            if (btn_level !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_level cycle %0d: got %b want 0", k, btn_level);
            end
        end
        tests_run++;
        if (busy_cnt != 3) begin
            tests_failed++;
            $display("FAIL glitch_busy_len: got %0d want 3", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        btn_in = 1'b1;
        for (int n = 0; n < L - 2; n++) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midwait_armed: busy got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (btn_level !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midwait_reset: level %b busy %b want 0 0", btn_level, busy);
        end
        for (int n = 1; n <= L + 2; n++) begin
            tick();
            tests_run++;
            if (btn_level !== (n >= L)) begin
                tests_failed++;
                $display("FAIL midwait_restart edge %0d: got %b want %b", n, btn_level, n >= L);
            end
        end
    endtask

    task automatic test_back_to_back();
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 2 * (S + L); k++) begin
                btn_in = (k < S);
                tick();
                tests_run++;
                if (btn_level !== m_level || busy !== (m_run != 0)) begin
                    tests_failed++;
                    $display("FAIL b2b rep %0d cycle %0d: level %b busy %b want %b %b",
                             rep, k, btn_level, busy, m_level, m_run != 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int last_change = -1;
        bit prev_level;
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        prev_level = btn_level;
        for (int cyc = 0; cyc < 800; ) begin
            int len;
            btn_in = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 2 * S + 2);
            for (int j = 0; j < len; j++) begin
                tick();
                cyc++;
                tests_run++;
                if (btn_level !== m_level || busy !== (m_run != 0)) begin
                    tests_failed++;
                    $display("FAIL random cycle %0d: level %b busy %b want %b %b",
                             cyc, btn_level, busy, m_level, m_run != 0);
                end
                if (btn_level !== prev_level) begin
                    if (last_change >= 0) begin
                        tests_run++;
                        if (cyc - last_change < S) begin
                            tests_failed++;
                            $display("FAIL random_min_gap: got %0d cycles want >= %0d",
                                     cyc - last_change, S);
                        end
                    end
                    last_change = cyc;
                    prev_level  = btn_level;
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 1000000 (10 ms at 100 MHz), the consecutive cycles a new input level must hold before being accepted; legal range 2 to 2^24.
REQ-002 The module SHALL have parameter CNT_W, default $clog2(STABLE_CYCLES), the counter width, and SHALL NOT be overridden independently.
REQ-003 The module SHALL have port clk, input, 1 bit, the sole clock, with all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The module SHALL have port btn_in, input, 1 bit, the raw asynchronous mechanical switch level.
REQ-006 The module SHALL have port btn_level, output, 1 bit, the debounced level, registered, intended to drive the enable input of the downstream single-cycle pulse stage.
REQ-007 The module SHALL have port busy, output, 1 bit, registered, high while a candidate level change is being timed.

Function
REQ-008 The module SHALL define internal sample s as the registered copy of btn_in taken through the input path of REQ-019/REQ-020.
REQ-009 The FSM SHALL have exactly four states: LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW.
REQ-010 In a *_STABLE state with s equal to btn_level, the FSM SHALL hold its state and the counter SHALL hold 0.
REQ-011 In a *_STABLE state with s not equal to btn_level, the next state SHALL be WAIT_HIGH or WAIT_LOW respectively, the counter SHALL become 1, and busy SHALL rise on that same edge.
REQ-012 In a WAIT state with s still differing from btn_level, the counter SHALL increment by 1 each cycle.
REQ-013 When the counter equals STABLE_CYCLES-1 and s still differs, the next edge SHALL toggle btn_level, clear the counter, clear busy, and enter the matching *_STABLE state.
REQ-014 In a WAIT state, if s equals btn_level on any cycle (a bounce), the FSM SHALL return to the prior *_STABLE state with counter 0 and busy 0, and btn_level SHALL be unchanged.
REQ-015 The counter SHALL never wrap, SHALL saturate by construction at STABLE_CYCLES-1, and SHALL be compared as unsigned CNT_W bits.
REQ-016 btn_level SHALL change at most once per STABLE_CYCLES cycles, and no single-cycle glitch on btn_in SHALL ever reach btn_level.

Reset
REQ-017 While rst is high at a clock edge, the module SHALL reset to: btn_level 0, busy 0, counter 0, state LOW_STABLE, and all synchronizer/sample flops 0.
REQ-018 Reset asserted during a WAIT state SHALL abandon the pending change, and timing SHALL restart from zero after rst deasserts.

Configuration
REQ-019 With macro DEBOUNCE_SYNC_EN defined, btn_in SHALL pass through a two-flop synchronizer before s, and btn_level SHALL change on the (STABLE_CYCLES+2)th rising edge after a clean btn_in change.
REQ-020 With DEBOUNCE_SYNC_EN undefined, btn_in SHALL be captured by a single flop as s, and the latency SHALL be STABLE_CYCLES+1 edges; this build is only for inputs already synchronous to clk.

Structure
REQ-021 The state enum and the default STABLE_CYCLES constant SHALL reside in shared package debounce_pkg.
REQ-022 The two-flop synchronizer SHALL be the separate sub-module sync_2ff (ports clk, rst, d, q), instantiated only under DEBOUNCE_SYNC_EN.

Verification (STABLE_CYCLES=4, DEBOUNCE_SYNC_EN defined unless noted)
REQ-023 The bench SHALL check a clean press: btn_in 0->1 held 10 cycles -> busy rises on edge 3, btn_level rises on edge 6, and busy falls on edge 6.
REQ-024 The bench SHALL check bounce: btn_in toggling every 2 cycles for 12 cycles then held 1 -> btn_level stays 0 throughout the bounce and rises 6 edges after the final 0->1.
REQ-025 The bench SHALL check a glitch: btn_in high for 3 cycles then low -> btn_level stays 0, and busy pulses high for 3 cycles.
REQ-026 The bench SHALL check release: from btn_level=1, btn_in 1->0 held -> btn_level falls on edge 6.
REQ-027 The bench SHALL check reset mid-wait: rst high for 1 cycle while counter=2 in WAIT_HIGH, btn_in held 1 -> btn_level 0, busy 0 after reset, and btn_level rises 6 edges after rst deasserts.
REQ-028 The bench SHALL check the build without DEBOUNCE_SYNC_EN: a clean btn_in 0->1 -> btn_level rises on edge 5.
